bcd_stopwatch: RTL and testbench
================================

BCD_STOPWATCH -- requirements
Module: bcd_stopwatch

Interface
REQ-001 SHALL have parameter TICK_DIV, default 500000, giving clk cycles per count step (minimum 2).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start_stop  input  1  synchronous level; acted on at its rising edge.
REQ-005 SHALL have port clear  input  1  synchronous level; acted on at its rising edge.
REQ-006 SHALL have port up_dn  input  1  count direction: 1 = up, 0 = down; sampled at each step.
REQ-007 SHALL have port digit0..digit3  output  4 each  BCD digits, digit0 least significant; each digit drives one seven-segment decoder.
REQ-008 SHALL have port running  output  1  high while state is RUN.
REQ-009 SHALL have port wrap  output  1  one-cycle pulse on the cycle after a count wraps.

Function
REQ-010 SHALL detect edges by registering start_stop and clear; an edge is current=1 and previous=0; one edge yields exactly one action.
REQ-011 SHALL implement an FSM with states IDLE, RUN and PAUSE.
REQ-012 SHALL transition IDLE->RUN, RUN->PAUSE and PAUSE->RUN on a start_stop edge.
REQ-013 SHALL, on a clear edge in any state, go to IDLE, set all digits to 0 and set the prescaler to 0 on that edge.
REQ-014 SHALL give clear priority over start_stop when both edges occur in the same cycle; result is IDLE.
REQ-015 SHALL run the prescaler 0..TICK_DIV-1 only in RUN, wrapping to 0 after TICK_DIV-1.
REQ-016 SHALL hold the prescaler in PAUSE, so resume continues the partial interval.
REQ-017 SHALL generate an internal step when state is RUN and prescaler equals TICK_DIV-1; digits update on that same clock edge.
REQ-018 SHALL produce the first step exactly TICK_DIV cycles after the edge that enters RUN from IDLE.
REQ-019 SHALL count up by incrementing digit0 and carrying into the next digit when a digit goes from 9 to 0.
REQ-020 SHALL count down by decrementing digit0 and borrowing from the next digit when a digit goes from 0 to 9.
REQ-021 SHALL wrap 9999 to 0000 when counting up and 0000 to 9999 when counting down, asserting wrap for exactly one cycle after the wrapping edge.
REQ-022 SHALL never hold a digit value above 9.
REQ-023 SHALL allow up_dn to change at any time; only its value at a step matters.
REQ-024 SHALL ignore a start_stop edge that coincides with a step for the count, so the step still occurs, and apply the state change.
REQ-025 SHALL drive running combinationally from the state register and wrap from a register.

Reset
REQ-026 SHALL, while rst_n=0, force state IDLE, digits 0, prescaler 0, edge registers 0, running 0 and wrap 0.
REQ-027 SHALL, after reset is applied mid-count, restart only through a new start_stop edge after rst_n deasserts.

Structure
REQ-028 SHALL place the state enum (IDLE, RUN, PAUSE) and the 4-bit BCD digit typedef in shared package display_pkg.
REQ-029 SHALL instantiate four copies of one sub-module bcd_digit (inputs: step, up_dn, carry_in; outputs: value, carry_out) chained by carry.
REQ-030 SHALL contain no combinational path from any input to any output.

Verification (TICK_DIV=4)
REQ-031 SHALL test reset then a start_stop edge: running=1 next cycle; digit0=1 after 4 cycles; digit0=3 after 12 cycles.
REQ-032 SHALL test up-count carry: run to 0009 then one step -> digits 0010; run to 9999 then one step -> 0000 with one wrap pulse.
REQ-033 SHALL test down-count wrap: up_dn=0 from 0000, one step -> 9999 with wrap=1 for exactly one cycle; next step -> 9998.
REQ-034 SHALL test pause/resume: pause at prescaler=2 and hold 20 cycles with digits frozen; resume -> next step 2 cycles later.
REQ-035 SHALL test simultaneous clear and start_stop edges in RUN: IDLE, digits 0000, running=0.
REQ-036 SHALL test rst_n pulsed low mid-count at 0421: outputs go to 0 immediately with no clock; no counting until a new start_stop edge.

Source files
------------

// File: rtl/display_pkg.sv
// Shared types for the BCD stopwatch: FSM state encoding and the BCD digit type.
package display_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam bcd_t        BCD_MAX    = 4'd9;

endpackage

// File: rtl/bcd_stopwatch_if.sv
// Control inputs and display outputs of the stopwatch, bundled for port connection.
interface bcd_stopwatch_if;
  import display_pkg::*;

  logic start_stop;
  logic clear;
  logic up_dn;
  bcd_t digit0;
  bcd_t digit1;
  bcd_t digit2;
  bcd_t digit3;
  logic running;
  logic wrap;

  modport master (
    output start_stop, clear, up_dn,
    input  digit0, digit1, digit2, digit3, running, wrap
  );

  modport slave (
    input  start_stop, clear, up_dn,
    output digit0, digit1, digit2, digit3, running, wrap
  );

endinterface

// File: rtl/bcd_digit.sv
// One BCD decade: counts up or down on step when carry_in is set, reports its own rollover.
module bcd_digit
  import display_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic step,
  input  logic up_dn,
  input  logic carry_in,
  output bcd_t value,
  output logic carry_out
);

  bcd_t r_value;
  bcd_t w_next;

  // Out-of-range values fold back to a legal digit so a digit never exceeds 9
  always_comb begin
    w_next = r_value;
    if (up_dn) begin
      w_next = (r_value >= BCD_MAX) ? 4'd0 : r_value + 4'd1;
    end else begin
      w_next = ((r_value == 4'd0) || (r_value > BCD_MAX)) ? BCD_MAX : r_value - 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= 4'd0;
    end else if (clr) begin
      r_value <= 4'd0;
    end else if (step && carry_in) begin
      r_value <= w_next;
    end
  end

  assign carry_out = carry_in & (up_dn ? (r_value == BCD_MAX) : (r_value == 4'd0));
  assign value     = r_value;

endmodule

// File: rtl/bcd_stopwatch.sv
// Four-digit up/down BCD stopwatch with start/stop and clear buttons and a prescaled step.
module bcd_stopwatch
  import display_pkg::*;
#(
  parameter int unsigned TICK_DIV = 500000
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_stopwatch_if.slave  bus
);

  localparam int unsigned   PW       = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic                  r_ss_q;
  logic                  r_clr_q;
  logic                  w_ss_edge;
  logic                  w_clr_edge;
  state_t                r_state;
  state_t                w_state_nxt;
  logic [PW-1:0]         r_pres;
  logic                  w_step;
  logic                  r_wrap;
  logic [NUM_DIGITS:0]   w_carry;
  bcd_t                  w_digit [NUM_DIGITS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ss_q  <= 1'b0;
      r_clr_q <= 1'b0;
    end else begin
      r_ss_q  <= bus.start_stop;
      r_clr_q <= bus.clear;
    end
  end

  assign w_ss_edge  = bus.start_stop & ~r_ss_q;
  assign w_clr_edge = bus.clear & ~r_clr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Clear wins over start_stop; start_stop toggles between RUN and PAUSE
  always_comb begin
    w_state_nxt = r_state;
    if (w_clr_edge) begin
      w_state_nxt = IDLE;
    end else if (w_ss_edge) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_step = (r_state == RUN) && (r_pres == PRE_LAST);

  // Prescaler freezes on the pausing edge so a resume finishes the partial interval
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pres <= '0;
    end else if (w_clr_edge || w_step) begin
      r_pres <= '0;
    end else if ((r_state == RUN) && !w_ss_edge) begin
      r_pres <= r_pres + PW'(1);
    end
  end

  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    bcd_digit u_digit (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (w_clr_edge),
      .step      (w_step),
      .up_dn     (bus.up_dn),
      .carry_in  (w_carry[gi]),
      .value     (w_digit[gi]),
      .carry_out (w_carry[gi+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrap <= 1'b0;
    end else begin
      r_wrap <= w_step & ~w_clr_edge & w_carry[NUM_DIGITS];
    end
  end

  assign bus.digit0  = w_digit[0];
  assign bus.digit1  = w_digit[1];
  assign bus.digit2  = w_digit[2];
  assign bus.digit3  = w_digit[3];
  assign bus.running = (r_state == RUN);
  assign bus.wrap    = r_wrap;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch at TICK_DIV=4: vector table plus reset/hold sequences.
module tb_bcd_stopwatch;

  typedef enum logic [1:0] {A_NONE, A_SS, A_CLR, A_BOTH} act_e;

  typedef struct {
    act_e        act;
    logic        up;
    int          waitn;
    logic [15:0] dig;
    logic        run;
    logic        wrp;
  } vec_t;

  typedef struct {
    string       name;
    logic [15:0] dig;
    logic        run;
    logic        wrp;
  } exp_t;

  localparam int NV = 23;

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];
  vec_t vec [NV];

  bcd_stopwatch_if bus();

  bcd_stopwatch #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic void chk(string name, logic [15:0] got, logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endfunction

  function automatic void push_exp(string name, logic [15:0] dig, logic run, logic wrp);
    exp_t e;
    e.name = name;
    e.dig  = dig;
    e.run  = run;
    e.wrp  = wrp;
    sb_q.push_back(e);
  endfunction

  function automatic void check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty got=0 exp=1");
      return;
    end
    e = sb_q.pop_front();
    chk({e.name, ".digits"}, {bus.digit3, bus.digit2, bus.digit1, bus.digit0}, e.dig);
    chk({e.name, ".running"}, 16'(bus.running), 16'(e.run));
    chk({e.name, ".wrap"}, 16'(bus.wrap), 16'(e.wrp));
  endfunction

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_action(input act_e act);
    if (act != A_NONE) begin
      bus.start_stop = (act == A_SS) || (act == A_BOTH);
      bus.clear      = (act == A_CLR) || (act == A_BOTH);
      step_n(1);
      bus.start_stop = 1'b0;
      bus.clear      = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    // count up, carry 0009->0010, clear, down-wrap, up-wrap, pause/resume, clear+start
    vec[0]  = '{A_SS,   1'b1, 0,  16'h0000, 1'b1, 1'b0};
    vec[1]  = '{A_NONE, 1'b1, 3,  16'h0000, 1'b1, 1'b0};
    vec[2]  = '{A_NONE, 1'b1, 1,  16'h0001, 1'b1, 1'b0};
    vec[3]  = '{A_NONE, 1'b1, 8,  16'h0003, 1'b1, 1'b0};
    vec[4]  = '{A_NONE, 1'b1, 24, 16'h0009, 1'b1, 1'b0};
    vec[5]  = '{A_NONE, 1'b1, 4,  16'h0010, 1'b1, 1'b0};
    vec[6]  = '{A_CLR,  1'b0, 0,  16'h0000, 1'b0, 1'b0};
    vec[7]  = '{A_SS,   1'b0, 0,  16'h0000, 1'b1, 1'b0};
    vec[8]  = '{A_NONE, 1'b0, 3,  16'h0000, 1'b1, 1'b0};
    vec[9]  = '{A_NONE, 1'b0, 1,  16'h9999, 1'b1, 1'b1};
    vec[10] = '{A_NONE, 1'b0, 1,  16'h9999, 1'b1, 1'b0};
    vec[11] = '{A_NONE, 1'b0, 3,  16'h9998, 1'b1, 1'b0};
    vec[12] = '{A_NONE, 1'b1, 4,  16'h9999, 1'b1, 1'b0};
    vec[13] = '{A_NONE, 1'b1, 4,  16'h0000, 1'b1, 1'b1};
    vec[14] = '{A_NONE, 1'b1, 1,  16'h0000, 1'b1, 1'b0};
    vec[15] = '{A_NONE, 1'b1, 1,  16'h0000, 1'b1, 1'b0};
    vec[16] = '{A_SS,   1'b1, 0,  16'h0000, 1'b0, 1'b0};
    vec[17] = '{A_NONE, 1'b1, 20, 16'h0000, 1'b0, 1'b0};
    vec[18] = '{A_SS,   1'b1, 0,  16'h0000, 1'b1, 1'b0};
    vec[19] = '{A_NONE, 1'b1, 1,  16'h0000, 1'b1, 1'b0};
    vec[20] = '{A_NONE, 1'b1, 1,  16'h0001, 1'b1, 1'b0};
    vec[21] = '{A_BOTH, 1'b1, 0,  16'h0000, 1'b0, 1'b0};
    vec[22] = '{A_NONE, 1'b1, 8,  16'h0000, 1'b0, 1'b0};

    rst_n          = 1'b0;
    bus.start_stop = 1'b0;
    bus.clear      = 1'b0;
    bus.up_dn      = 1'b1;
    step_n(3);
    push_exp("reset", 16'h0000, 1'b0, 1'b0);
    check_out();
    #3 rst_n = 1'b1;
    step_n(2);

    // Held start_stop is a single edge: one IDLE->RUN, counting continues
    bus.start_stop = 1'b1;
    push_exp("hold_ss", 16'h0002, 1'b1, 1'b0);
    step_n(10);
    check_out();
    bus.start_stop = 1'b0;
    push_exp("hold_clr", 16'h0000, 1'b0, 1'b0);
    do_action(A_CLR);
    check_out();

    for (int i = 0; i < NV; i++) begin
      bus.up_dn = vec[i].up;
      push_exp($sformatf("vec%0d", i), vec[i].dig, vec[i].run, vec[i].wrp);
      do_action(vec[i].act);
      step_n(vec[i].waitn);
      check_out();
    end

    // Asynchronous reset mid-count at 0421, then restart only via a new start_stop edge
    bus.up_dn = 1'b1;
    push_exp("rst_start", 16'h0000, 1'b1, 1'b0);
    do_action(A_SS);
    check_out();
    push_exp("rst_0421", 16'h0421, 1'b1, 1'b0);
    step_n(1684);
    check_out();
    step_n(1);
    #2 rst_n = 1'b0;
    #1;
    push_exp("rst_async", 16'h0000, 1'b0, 1'b0);
    check_out();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    push_exp("rst_idle", 16'h0000, 1'b0, 1'b0);
    step_n(20);
    check_out();
    push_exp("rst_restart", 16'h0000, 1'b1, 1'b0);
    do_action(A_SS);
    check_out();
    push_exp("rst_first_step", 16'h0001, 1'b1, 1'b0);
    step_n(4);
    check_out();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
